param_univ_reg: RTL

PARAM_UNIV_REG -- requirements
Module: param_univ_reg

---
 rtl/univ_reg_pkg.sv | 33 +++
 rtl/univ_reg_next.sv | 61 ++++++
 rtl/param_univ_reg.sv | 81 ++++++++
 3 files changed

// File: rtl/univ_reg_pkg.sv
// rtl/univ_reg_pkg.sv - MODE encoding constants and mode type for param_univ_reg
//
// Purpose: shared MODE encoding used by param_univ_reg and univ_reg_next.
// Ports:   none (package).

package univ_reg_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SHR  = 3'b001;
   localparam logic [2:0] MODE_SHL  = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_UP   = 3'b100;
   localparam logic [2:0] MODE_DOWN = 3'b101;
   localparam logic [2:0] MODE_ROR  = 3'b110;
   localparam logic [2:0] MODE_ROL  = 3'b111;

   typedef enum logic [2:0] {
      M_HOLD = MODE_HOLD,
      M_SHR  = MODE_SHR,
      M_SHL  = MODE_SHL,
      M_LOAD = MODE_LOAD,
      M_UP   = MODE_UP,
      M_DOWN = MODE_DOWN,
      M_ROR  = MODE_ROR,
      M_ROL  = MODE_ROL
   } mode_e;

   // Modes that advance only when both count enables are high.
   function automatic logic mode_gated(input logic [2:0] mode);
      return (mode != MODE_HOLD) && (mode != MODE_LOAD);
   endfunction

endpackage

// File: rtl/univ_reg_next.sv
// rtl/univ_reg_next.sv - combinational next-state selection for param_univ_reg
//
// Purpose: computes the candidate next register value for the selected MODE,
//          and flags when a count takes its wrap branch.
// Ports:   q       in  WIDTH  current register value
//          mode    in  3      operation select
//          d       in  WIDTH  parallel load data
//          sr, sl  in  1      serial inputs for right / left shift
//          q_next  out WIDTH  candidate next value
//          wrap    out 1      count wrapped (up past MOD-1 or down past 0)

import univ_reg_pkg::*;

module univ_reg_next #(
   parameter int unsigned     WIDTH  = 8,
   parameter logic [WIDTH-1:0] MOD_M1 = '1
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sr,
   input  logic             sl,
   output logic [WIDTH-1:0] q_next,
   output logic             wrap
);

   mode_e mode_sel;
   assign mode_sel = mode_e'(mode);

   always_comb begin
      q_next = q;
      wrap   = 1'b0;
      case (mode_sel)
         M_HOLD: q_next = q;
         M_SHR:  q_next = {sr, q[WIDTH-1:1]};
         M_SHL:  q_next = {q[WIDTH-2:0], sl};
         M_LOAD: q_next = d;
         M_UP: begin
            // >= so that an out-of-range loaded value wraps straight to 0
            if (q >= MOD_M1) begin
               q_next = '0;
               wrap   = 1'b1;
            end else begin
               q_next = q + 1'b1;
            end
         end
         M_DOWN: begin
            if (q == '0) begin
               q_next = MOD_M1;
               wrap   = 1'b1;
            end else begin
               q_next = q - 1'b1;
            end
         end
         M_ROR:  q_next = {q[0], q[WIDTH-1:1]};
         M_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/param_univ_reg.sv
// rtl/param_univ_reg.sv - parameterised universal shift register / modulo counter
//
// Purpose: WIDTH-bit register with hold, shift, rotate, load and modulo-MOD
//          up/down count; cascadable through RCO -> ENT.
// Ports:   CLK     in  1      clock, rising edge
//          CLR_n   in  1      asynchronous active-low reset
//          SCLR_n  in  1      synchronous active-low clear
//          MODE    in  3      operation select (see univ_reg_pkg)
//          ENP     in  1      count/shift enable
//          ENT     in  1      count/shift enable, also gates RCO
//          D       in  WIDTH  parallel load data
//          SR, SL  in  1      serial inputs for right / left shift
//          Q       out WIDTH  register state
//          RCO     out 1      combinational ripple carry
//          WRAP    out 1      registered one-cycle pulse after a count wrap

import univ_reg_pkg::*;

module param_univ_reg #(
   parameter int unsigned      WIDTH = 8,
   parameter longint unsigned  MOD   = 64'd1 << WIDTH
) (
   input  logic             CLK,
   input  logic             CLR_n,
   input  logic             SCLR_n,
   input  logic [2:0]       MODE,
   input  logic             ENP,
   input  logic             ENT,
   input  logic [WIDTH-1:0] D,
   input  logic             SR,
   input  logic             SL,
   output logic [WIDTH-1:0] Q,
   output logic             RCO,
   output logic             WRAP
);

   // Terminal count, computed in 64 bits so MOD = 2**32 is representable.
   localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MOD - 64'd1);

   logic [WIDTH-1:0] q_next;
   logic             next_wrap;
   logic             enabled;

   univ_reg_next #(
      .WIDTH  (WIDTH),
      .MOD_M1 (MOD_M1)
   ) u_next (
      .q      (Q),
      .mode   (MODE),
      .d      (D),
      .sr     (SR),
      .sl     (SL),
      .q_next (q_next),
      .wrap   (next_wrap)
   );

   assign enabled = ENP & ENT;

   always_ff @(posedge CLK or negedge CLR_n) begin
      if (!CLR_n) begin
         Q    <= '0;
         WRAP <= 1'b0;
      end else if (!SCLR_n) begin
         Q    <= '0;
         WRAP <= 1'b0;
      end else if (MODE == MODE_LOAD) begin
         Q    <= q_next;
         WRAP <= 1'b0;
      end else if (mode_gated(MODE) && enabled) begin
         Q    <= q_next;
         WRAP <= next_wrap;
      end else begin
         WRAP <= 1'b0;
      end
   end

   // No ENP term so a stalled lower stage still presents its carry upstream.
   assign RCO = ENT & (((MODE == MODE_UP)   && (Q == MOD_M1)) ||
                       ((MODE == MODE_DOWN) && (Q == '0)));

endmodule
